// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage of the RV64 core. Accepts one load or store at a time
// from the decoder. It runs a request/grant/response handshake with a 64-bit
// data memory and returns a single-cycle completion to writeback, carrying
// sign- or zero-extended load data.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready upstream handshake; ready only in IDLE, out of reset
//   mem_read/mem_write  operation type from the decoder
//   funct3              access size [1:0] and load zero-extend flag [2]
//   addr                effective byte address
//   store_data          rs2 value for stores
//   rd                  destination register tag
//   resp_valid          one-cycle completion pulse
//   resp_we             writeback enable (successful load only)
//   resp_rd             tag of the completing operation
//   resp_data           extended load data, 0 for stores and errors
//   resp_err            misaligned access or illegal encoding
//   dmem_req/dmem_gnt   memory request, held until granted
//   dmem_we             1 = write
//   dmem_addr           doubleword-aligned address
//   dmem_wdata          lane-replicated store data
//   dmem_be             byte enables
//   dmem_rvalid         read data valid
//   dmem_rdata          read doubleword
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  input  logic [4:0]        rd,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [63:0]       resp_data,
  output logic              resp_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [63:0]       dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state;
  state_t state_next;

  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic              req_err;
  logic [7:0]        be_new;
  logic [63:0]       wdata_new;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              is_load_q;
  logic              err_q;
  logic              we_q;
  logic [7:0]        be_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;

  logic [63:0]       shifted;
  logic [63:0]       load_ext;
  logic              sign_ext;
  logic              capture;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Classify the incoming request and precompute its memory-side lanes so
  // they can be registered once at accept and held stable during REQ.
  always_comb begin
    illegal    = (mem_read == mem_write)
               || (mem_read && (funct3 == 3'b111))
               || (mem_write && funct3[2]);
    misaligned = 1'b0;
    be_new     = 8'h00;
    wdata_new  = 64'd0;
    case (funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        be_new     = 8'h01 << addr[2:0];
        wdata_new  = {8{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_new     = 8'h03 << addr[2:0];
        wdata_new  = {4{store_data[15:0]}};
      end
      2'b10: begin
        misaligned = |addr[1:0];
        be_new     = 8'h0F << addr[2:0];
        wdata_new  = {2{store_data[31:0]}};
      end
      default: begin
        misaligned = |addr[2:0];
        be_new     = 8'hFF;
        wdata_new  = store_data;
      end
    endcase
    // Loads always fetch the whole doubleword and pick the lanes out later.
    if (mem_read) begin
      be_new = 8'hFF;
    end
    req_err = illegal || misaligned;
  end

  // Load extraction: shift the addressed byte down to lane 0, truncate to
  // the access size, then sign- or zero-extend.
  always_comb begin
    shifted  = dmem_rdata >> {addr_q[2:0], 3'b000};
    sign_ext = !funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Read data is taken either together with the grant or later in WAIT.
  assign capture = (state == REQ && dmem_gnt && dmem_rvalid && is_load_q)
                || (state == WAIT && dmem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_err ? RESP : REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (!is_load_q || dmem_rvalid) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operation latches. Load data is cleared at accept so stores and errors
  // complete with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      funct3_q  <= 3'd0;
      rd_q      <= 5'd0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 8'h00;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
    end else if (accept) begin
      addr_q    <= addr;
      funct3_q  <= funct3;
      rd_q      <= rd;
      is_load_q <= mem_read && !mem_write;
      err_q     <= req_err;
      we_q      <= mem_write && !mem_read;
      be_q      <= be_new;
      wdata_q   <= wdata_new;
      rdata_q   <= 64'd0;
    end else if (capture) begin
      rdata_q   <= load_ext;
    end
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  assign resp_valid = (state == RESP);
  assign resp_we    = resp_valid && is_load_q && !err_q;
  assign resp_err   = resp_valid && err_q;
  assign resp_rd    = resp_valid ? rd_q : 5'd0;
  assign resp_data  = resp_valid ? rdata_q : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed stimulus for load_store_unit. Each operation is run through a
// behavioural model that derives the expected completion and memory-side
// values from the access rules. A single compare process checks the DUT
// against the pending expectations on every falling edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        err;
    int          resp_cyc;
    logic [31:0] maddr;
    logic        mwe;
    logic [7:0]  be;
    logic [63:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  int          cyc;
  logic        exp_v;
  logic        saw_req;
  logic [63:0] last_data;
  logic        last_we;
  logic        last_err;
  logic [4:0]  last_rd;
  int          last_cyc;
  logic [7:0]  last_be;
  logic [63:0] last_wdata;
  logic [31:0] last_maddr;
  logic        last_mwe;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd(rd),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Expected behaviour of one operation, derived from the access rules:
  // legality, alignment, byte lanes, replication and load extension.
  function automatic exp_t model(input logic mr, input logic mw,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [63:0] sd, input logic [4:0] rdt,
                                 input logic [63:0] rdat);
    exp_t        e;
    int          nbytes;
    int          off;
    logic        illegal;
    logic        mis;
    logic [15:0] t;
    logic [63:0] val;
    logic [63:0] mask;
    nbytes  = 1 << f3[1:0];
    off     = int'(a[2:0]);
    illegal = (mr == mw) || (mr && f3 == 3'b111) || (mw && f3[2]);
    mis     = (off % nbytes) != 0;
    e.err   = illegal || mis;
    e.rd    = rdt;
    e.maddr = {a[31:3], 3'b000};
    e.mwe   = mw;
    t       = 16'((1 << nbytes) - 1) << off;
    e.be    = mr ? 8'hFF : t[7:0];
    e.wdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      e.wdata[8*i +: 8] = sd[8*(i % nbytes) +: 8];
    end
    e.we = mr && !e.err;
    if (e.we) begin
      val  = rdat >> (8 * off);
      mask = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                           : ((64'd1 << (8 * nbytes)) - 64'd1);
      val  = val & mask;
      if (!f3[2] && val[8*nbytes-1]) begin
        val = val | ~mask;
      end
      e.data = val;
    end else begin
      e.data = 64'd0;
    end
    e.resp_cyc = 0;
    return e;
  endfunction

  // Compare process: runs every falling edge against the pending expectations.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
      checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    end else begin
      checkOutput("req_ready", 64'(req_ready), 64'(q.size() == 0));
      if (dmem_req) begin
        saw_req    = 1'b1;
        last_be    = dmem_be;
        last_wdata = dmem_wdata;
        last_maddr = dmem_addr;
        last_mwe   = dmem_we;
        if (q.size() == 0 || q[0].err) begin
          checkOutput("dmem_req_spurious", 64'(dmem_req), 64'd0);
        end else begin
          checkOutput("dmem_addr", 64'(dmem_addr), 64'(q[0].maddr));
          checkOutput("dmem_we", 64'(dmem_we), 64'(q[0].mwe));
          checkOutput("dmem_be", 64'(dmem_be), 64'(q[0].be));
          checkOutput("dmem_wdata", dmem_wdata, q[0].wdata);
        end
      end
      exp_v = (q.size() != 0) && (q[0].resp_cyc == cyc);
      checkOutput("resp_valid", 64'(resp_valid), 64'(exp_v));
      if (exp_v) begin
        checkOutput("resp_rd", 64'(resp_rd), 64'(q[0].rd));
        checkOutput("resp_data", resp_data, q[0].data);
        checkOutput("resp_we", 64'(resp_we), 64'(q[0].we));
        checkOutput("resp_err", 64'(resp_err), 64'(q[0].err));
        last_data = resp_data;
        last_we   = resp_we;
        last_err  = resp_err;
        last_rd   = resp_rd;
        last_cyc  = cyc;
        void'(q.pop_front());
      end
    end
  end

  // One complete operation. gd = grant-low cycles in REQ; rvd = cycles from
  // the grant cycle to rvalid (0 means same cycle as the grant).
  task automatic applyStimulus(input logic mr, input logic mw,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [63:0] sd, input logic [4:0] rdt,
                               input logic [63:0] rdat, input int gd,
                               input int rvd);
    exp_t e;
    int   n;
    e = model(mr, mw, f3, a, sd, rdt, rdat);
    if (e.err)   e.resp_cyc = cyc + 1;
    else if (mr) e.resp_cyc = cyc + 2 + gd + rvd;
    else         e.resp_cyc = cyc + 2 + gd;
    saw_req    = 1'b0;
    req_valid  = 1'b1;
    mem_read   = mr;
    mem_write  = mw;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd         = rdt;
    @(posedge clk);
    q.push_back(e);
    #1;
    req_valid = 1'b0;
    if (!e.err) begin
      repeat (gd) begin
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
      end
      dmem_gnt = 1'b1;
      if (mr && rvd == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdat;
      end else if (!mr) begin
        // rvalid noise during a store grant must be ignored
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
      end
      @(posedge clk); #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (mr && rvd > 0) begin
        repeat (rvd - 1) begin
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdat;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
      end
    end
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("resp_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    saw_req     = 1'b0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'd0;
    addr        = 32'd0;
    store_data  = 64'd0;
    rd          = 5'd0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_resp_data", resp_data, 64'd0);
    checkOutput("reset_dmem_be", 64'(dmem_be), 64'd0);
    @(posedge clk); #1;

    $display("[TB] LD with immediate grant");
    applyStimulus(1, 0, 3'b011, 32'h100, 64'd0, 5'd5,
                  64'h8877_6655_4433_2211, 0, 1);
    checkOutput("ld_data_lit", last_data, 64'h8877_6655_4433_2211);
    checkOutput("ld_we_lit", 64'(last_we), 64'd1);
    checkOutput("ld_rd_lit", 64'(last_rd), 64'd5);

    $display("[TB] LB / LBU / LWU / LW extension");
    applyStimulus(1, 0, 3'b000, 32'h103, 64'd0, 5'd6,
                  64'h0123_4567_80AA_BBCC, 0, 1);
    checkOutput("lb_data_lit", last_data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1, 0, 3'b100, 32'h103, 64'd0, 5'd7,
                  64'h0123_4567_80AA_BBCC, 1, 2);
    checkOutput("lbu_data_lit", last_data, 64'h0000_0000_0000_0080);
    applyStimulus(1, 0, 3'b110, 32'h104, 64'd0, 5'd8,
                  64'h8000_0000_1234_5678, 0, 1);
    checkOutput("lwu_data_lit", last_data, 64'h0000_0000_8000_0000);
    applyStimulus(1, 0, 3'b010, 32'h104, 64'd0, 5'd9,
                  64'h8000_0000_1234_5678, 0, 1);

    $display("[TB] SH with delayed grant");
    applyStimulus(0, 1, 3'b001, 32'h106, 64'hDEAD_BEEF_CAFE_1234, 5'd10,
                  64'd0, 3, 0);
    checkOutput("sh_be_lit", 64'(last_be), 64'hC0);
    checkOutput("sh_wdata_lit", last_wdata, 64'h1234_1234_1234_1234);
    checkOutput("sh_addr_lit", 64'(last_maddr), 64'h100);
    checkOutput("sh_we_lit", 64'(last_mwe), 64'd1);
    checkOutput("sh_data_zero", last_data, 64'd0);

    $display("[TB] other stores");
    applyStimulus(0, 1, 3'b000, 32'h205, 64'h0000_0000_0000_00AB, 5'd11,
                  64'd0, 1, 0);
    checkOutput("sb_be_lit", 64'(last_be), 64'h20);
    applyStimulus(0, 1, 3'b010, 32'h204, 64'h5555_6666_1122_3344, 5'd12,
                  64'd0, 0, 0);
    applyStimulus(0, 1, 3'b011, 32'h208, 64'h0102_0304_0506_0708, 5'd13,
                  64'd0, 0, 0);

    $display("[TB] misaligned and illegal");
    applyStimulus(1, 0, 3'b010, 32'h102, 64'd0, 5'd14, 64'd0, 0, 0);
    checkOutput("lw_mis_err_lit", 64'(last_err), 64'd1);
    checkOutput("lw_mis_noreq", 64'(saw_req), 64'd0);
    applyStimulus(1, 1, 3'b011, 32'h100, 64'd0, 5'd15, 64'd0, 0, 0);
    checkOutput("rw_both_err_lit", 64'(last_err), 64'd1);
    applyStimulus(0, 0, 3'b011, 32'h100, 64'd0, 5'd16, 64'd0, 0, 0);
    applyStimulus(1, 0, 3'b111, 32'h100, 64'd0, 5'd17, 64'd0, 0, 0);
    applyStimulus(0, 1, 3'b100, 32'h100, 64'd0, 5'd18, 64'd0, 0, 0);
    applyStimulus(0, 1, 3'b011, 32'h20C, 64'd0, 5'd19, 64'd0, 0, 0);
    applyStimulus(0, 1, 3'b001, 32'h201, 64'd0, 5'd20, 64'd0, 0, 0);

    $display("[TB] same-cycle grant and rvalid");
    applyStimulus(1, 0, 3'b001, 32'h10A, 64'd0, 5'd21,
                  64'h1111_2222_FEDC_3333, 0, 0);
    checkOutput("lh_data_lit", last_data, 64'hFFFF_FFFF_FFFF_FEDC);
    applyStimulus(1, 0, 3'b011, 32'h300, 64'd0, 5'd22,
                  64'h0F0E_0D0C_0B0A_0908, 2, 3);

    $display("[TB] reset mid-operation");
    saw_req   = 1'b0;
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = 3'b011;
    addr      = 32'h400;
    rd        = 5'd23;
    @(posedge clk);
    q.push_back(model(1, 0, 3'b011, 32'h400, 64'd0, 5'd23, 64'd0));
    q[0].resp_cyc = cyc + 100;
    #1;
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    @(posedge clk); #1;
    dmem_gnt  = 1'b0;
    rst       = 1'b1;
    q.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    applyStimulus(0, 1, 3'b011, 32'h408, 64'hCAFE_F00D_0BAD_BEEF, 5'd24,
                  64'd0, 0, 0);
    checkOutput("sd_after_rst_rd", 64'(last_rd), 64'd24);
    checkOutput("sd_after_rst_be", 64'(last_be), 64'hFF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV64 core. It sits directly downstream of the decoder and consumes its `mem_read` / `mem_write` control together with `funct3`, the ALU-computed address and the rs2 store data. It runs a request/grant/response handshake with the 64-bit data memory and returns sign- or zero-extended load data, tagged with the destination register, to writeback.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: upstream presents a memory operation.
- `req_ready` out 1: unit accepts an operation. Equals (state==IDLE) && !rst.
- `mem_read` in 1: load request, from the decoder.
- `mem_write` in 1: store request, from the decoder.
- `funct3` in 3: access size and signedness.
- `addr` in ADDR_W: effective byte address.
- `store_data` in 64: rs2 value.
- `rd` in 5: destination register tag.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_we` out 1: writeback required (successful load only).
- `resp_rd` out 5: tag of the completing operation.
- `resp_data` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal encoding.
- `dmem_req` out 1: memory request, held until granted.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out ADDR_W: doubleword-aligned address, {addr[ADDR_W-1:3], 3'b000}.
- `dmem_wdata` out 64: lane-replicated store data.
- `dmem_be` out 8: byte enables.
- `dmem_gnt` in 1: memory accepted the request.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 64: read doubleword.

## Operation
- FSM states are IDLE, REQ, WAIT and RESP. Reset state is IDLE.
- All registered outputs reset to 0: `resp_*`, `dmem_*` and internal latches.
- **IDLE**: on `req_valid && req_ready`, latch `addr`, `funct3`, `rd`, `store_data` and the op type. Then decide the next state:
  - Legal and aligned: go to REQ.
  - Otherwise: go to RESP with err = 1.
- **Illegal encodings**:
  - `mem_read` and `mem_write` both 1, or both 0.
  - Load with `funct3` = 111.
  - Store with `funct3[2]` = 1.
- **Misalignment**: size 2 with addr[0] != 0; size 4 with addr[1:0] != 0; size 8 with addr[2:0] != 0. A misaligned or illegal request never asserts `dmem_req`.
- **Sizes**: `funct3[1:0]` selects 00 = byte, 01 = half, 10 = word, 11 = double. For loads, `funct3[2]` = 1 means zero-extend (LBU/LHU/LWU).
- **Store byte enables**: SB gives 8'h01<<a, SH gives 8'h03<<a, SW gives 8'h0F<<a, SD gives 8'hFF, where a = addr[2:0]. `dmem_wdata` replicates the low 1/2/4/8 bytes of `store_data` across all lanes.
- **Loads**: `dmem_be` = 8'hFF and `dmem_we` = 0. Extraction takes `dmem_rdata >> (8*addr[2:0])`, truncates to the access size, then sign- or zero-extends to 64 bits.
- **REQ**: `dmem_req` = 1 with stable address, data and enables.
  - On `dmem_gnt`, a store goes to RESP.
  - On `dmem_gnt`, a load goes to WAIT. If `dmem_rvalid` is also 1 in that cycle, the load captures `dmem_rdata` and goes straight to RESP.
- **WAIT**: `dmem_req` = 0. On `dmem_rvalid`, capture and extend the data, then go to RESP.
- **RESP**: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - `resp_we` = 1 only for a load with err = 0.
  - `resp_rd` = latched `rd`.
- **Ignored inputs**: `dmem_rvalid` is ignored in IDLE, REQ-for-store and RESP. `dmem_gnt` is ignored outside REQ.
- There is no response backpressure; the consumer always accepts.

## Timing
- Cycle 0 is the accept cycle.
- Latency with `dmem_gnt` granted in cycle 1:
  - Store: `resp_valid` in cycle 2.
  - Load with `dmem_rvalid` in cycle 2: `resp_valid` in cycle 3.
  - Load with `dmem_rvalid` in cycle 1 (same cycle as the grant): `resp_valid` in cycle 2.
  - Error: `resp_valid` in cycle 1.
- Each extra cycle without grant or rvalid adds exactly one cycle of latency.
- `req_ready` is 0 from cycle 1 until the cycle after `resp_valid`. The next accept is possible in the cycle after RESP.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronously) and the in-flight operation is discarded with no `resp_valid`. A late `dmem_rvalid` after reset is ignored.
- `dmem_addr`, `dmem_wdata`, `dmem_be` and `dmem_we` are constant for the whole time `dmem_req` is high.

## Test plan
- **LD, immediate grant**: addr = 0x100, `dmem_rdata` = 64'h8877665544332211 in cycle 2 -> `resp_valid` in cycle 3 with `resp_data` = 64'h8877665544332211, `resp_we` = 1, `resp_rd` = rd.
- **LB / LBU**: addr = 0x103, rdata byte 3 = 0x80 -> LB returns 64'hFFFFFFFFFFFFFF80; LBU returns 64'h80. LWU at 0x104 with upper word 0x80000000 -> 64'h0000000080000000.
- **SH**: addr = 0x106, `store_data` = 0x1234 -> `dmem_be` = 8'hC0, `dmem_wdata` = 64'h1234123412341234, `dmem_addr` = 0x100, `dmem_we` = 1. Hold `dmem_gnt` low for 3 cycles -> request is stable throughout and `resp_valid` arrives 1 cycle after the grant.
- **Misaligned and illegal**: LW at 0x102 -> `resp_err` = 1 in cycle 1, `dmem_req` never asserted. A request with `mem_read` = `mem_write` = 1 -> `resp_err` = 1.
- **Same-cycle grant and rvalid**: load with `dmem_gnt` and `dmem_rvalid` both high in cycle 1 -> `resp_valid` in cycle 2.
- **Reset mid-operation**: assert `rst` in WAIT -> `dmem_req`, `resp_valid` and `req_ready` are 0 while reset is held. Deassert reset, then pulse `dmem_rvalid` -> no response. A new SD afterwards completes normally.
